full_adder_1bit: RTL and testbench
==================================

Name: full_adder_1bit

Overview:
- 1-bit full adder: sum = a XOR b XOR cin, co = majority(a, b, cin).
- Optional output pipeline with valid tracking.
- Optional bit-serial mode: the carry comes from an internal carry register, so multi-bit operands can be added LSB-first over successive cycles.
- Leaf arithmetic cell used in ripple adders and serial datapaths.

Parameters:
- LATENCY, 0, number of output register stages (0..3). 0 = purely combinational sum/co; out_valid = in_valid.
- SERIAL_EN, 1, 1 = serial mode (serial_en, carry register) is implemented; 0 = serial_en is ignored and the carry register is tied to 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  1  addend bit
- b  input  1  addend bit
- cin  input  1  external carry-in
- in_valid  input  1  input bits are valid this cycle
- serial_en  input  1  1 = use the internal carry register instead of cin
- serial_start  input  1  first bit of a serial word; the carry register is treated as 0 for this bit
- sum  output  1  sum bit (after LATENCY stages)
- co  output  1  carry-out bit (after LATENCY stages)
- out_valid  output  1  sum/co are valid
- carry_q  output  1  current internal serial carry register value

Behaviour:
- Effective carry:
  - c_eff = cin when serial_en=0.
  - c_eff = (serial_start ? 0 : carry_q) when serial_en=1.
- Arithmetic, combinational: s0 = a^b^c_eff; c0 = (a&b)|(a&c_eff)|(b&c_eff). No X-propagation special-casing.
- Truth table (a,b,c_eff -> sum,co), all 8 combinations mandatory:
  - 000->0,0; 010->1,0; 100->1,0; 110->0,1
  - 001->1,0; 011->0,1; 101->0,1; 111->1,1
- LATENCY=0:
  - sum=s0, co=c0, out_valid=in_valid, all combinational.
  - rst affects only carry_q.
- LATENCY=N>0:
  - Shift register of N stages holding {s0, c0, in_valid}; stage advances every clock regardless of valid.
  - Outputs appear exactly N rising edges after inputs are sampled.
  - Stage data is captured even when in_valid=0 (data don't-care; valid bit carries 0).
- Carry register (serial mode):
  - On a rising edge with in_valid=1 and serial_en=1, carry_q <= c0.
  - Otherwise carry_q holds.
  - serial_en=0 never updates carry_q.
  - serial_start=1 with in_valid=0 does not clear carry_q.
- Reset (synchronous, rst=1 at the rising edge):
  - carry_q <= 0; all pipeline stages <= 0, so registered sum=0, co=0, out_valid=0.
  - rst has priority over simultaneous in_valid or serial_start.
  - Inputs present during the reset cycle are discarded.
  - Reset mid-serial-word aborts the word; the next word must assert serial_start (even if omitted, carry_q is already 0).
- No handshake backpressure: the block always accepts input.
- SERIAL_EN=0: carry_q output is constant 0; c_eff is always cin.

Test Plan:
- Exhaustive combinational check, LATENCY=0, serial_en=0. Apply (a,b,cin) = 000, 010, 100, 110, 001, 011, 101, 111, each held 100 ns. Required sum/co = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- Pipeline latency, LATENCY=2. Apply a=1,b=1,cin=1, in_valid=1 for one cycle, then in_valid=0. Required: sum=1, co=1, out_valid=1 exactly 2 edges later for one cycle, then out_valid=0.
- Serial 4-bit add 0b1011 + 0b0111, LSB first, serial_start on bit 0, serial_en=1. Required sum bits (LSB first) = 0,1,0,0, final carry_q=1, giving result 0b1_0010 (18).
- Serial with serial_start mid-stream. With carry_q=1, assert serial_start with a=0,b=0. Required sum=0, co=0, carry_q becomes 0.
- Reset priority, LATENCY=1. Drive rst=1 together with in_valid=1, a=1, b=1, serial_en=1. Required after the edge: carry_q=0, sum=0, co=0, out_valid=0. After rst drops, normal operation resumes with the next sample.
- serial_en=0 isolation. Set carry_q=1 via serial mode, then apply serial_en=0, cin=0, a=1, b=0 with in_valid=1. Required sum=1, co=0, carry_q stays 1.

Source files
------------

// File: rtl/full_adder_1bit_if.sv
// Bit-level operand/result bundle for full_adder_1bit.
// master drives the operand bits, slave is the adder cell.
interface full_adder_1bit_if;
  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic serial_en;
  logic serial_start;
  logic sum;
  logic co;
  logic out_valid;
  logic carry_q;

  modport master (
    output a, b, cin, in_valid, serial_en, serial_start,
    input  sum, co, out_valid, carry_q
  );

  modport slave (
    input  a, b, cin, in_valid, serial_en, serial_start,
    output sum, co, out_valid, carry_q
  );
endinterface

// File: rtl/full_adder_1bit.sv
// 1-bit full adder with optional output pipeline (LATENCY 0..3) and an
// optional internal carry register for LSB-first bit-serial addition.
module full_adder_1bit #(
  parameter int LATENCY   = 0,
  parameter int SERIAL_EN = 1
) (
  input logic          clk,
  input logic          rst,
  full_adder_1bit_if.slave bus
);

  logic c_eff;
  logic s0;
  logic c0;
  logic carry_r;

  always_comb begin
    c_eff = bus.cin;
    if ((SERIAL_EN != 0) && bus.serial_en) begin
      c_eff = bus.serial_start ? 1'b0 : carry_r;
    end
  end

  assign s0 = bus.a ^ bus.b ^ c_eff;
  assign c0 = (bus.a & bus.b) | (bus.a & c_eff) | (bus.b & c_eff);

  generate
    if (SERIAL_EN != 0) begin : g_carry
      // Only a valid serial bit advances the word carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          carry_r <= 1'b0;
        end else if (bus.in_valid && bus.serial_en) begin
          carry_r <= c0;
        end
      end
    end else begin : g_no_carry
      assign carry_r = 1'b0;
    end
  endgenerate

  assign bus.carry_q = carry_r;

  generate
    if (LATENCY == 0) begin : g_comb
      assign bus.sum       = s0;
      assign bus.co        = c0;
      assign bus.out_valid = bus.in_valid;
    end else begin : g_pipe
      // Each stage holds {sum, co, valid}; shifts every clock, valid or not.
      logic [2:0] stage_q [LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= 3'b000;
          end
        end else begin
          stage_q[0] <= {s0, c0, bus.in_valid};
          for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign {bus.sum, bus.co, bus.out_valid} = stage_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_1bit.sv
// Self-checking bench: directed plan checks plus randomized stimulus compared
// each cycle against an arithmetic model for LATENCY 0..3 and SERIAL_EN=0.
module tb_full_adder_1bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, cin = 1'b0;
  logic in_valid = 1'b0, serial_en = 1'b0, serial_start = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  full_adder_1bit_if if_l0 ();
  full_adder_1bit_if if_l1 ();
  full_adder_1bit_if if_l2 ();
  full_adder_1bit_if if_l3 ();
  full_adder_1bit_if if_ns ();

  assign {if_l0.a, if_l0.b, if_l0.cin, if_l0.in_valid, if_l0.serial_en, if_l0.serial_start} = {a, b, cin, in_valid, serial_en, serial_start};
  assign {if_l1.a, if_l1.b, if_l1.cin, if_l1.in_valid, if_l1.serial_en, if_l1.serial_start} = {a, b, cin, in_valid, serial_en, serial_start};
  assign {if_l2.a, if_l2.b, if_l2.cin, if_l2.in_valid, if_l2.serial_en, if_l2.serial_start} = {a, b, cin, in_valid, serial_en, serial_start};
  assign {if_l3.a, if_l3.b, if_l3.cin, if_l3.in_valid, if_l3.serial_en, if_l3.serial_start} = {a, b, cin, in_valid, serial_en, serial_start};
  assign {if_ns.a, if_ns.b, if_ns.cin, if_ns.in_valid, if_ns.serial_en, if_ns.serial_start} = {a, b, cin, in_valid, serial_en, serial_start};

  full_adder_1bit #(.LATENCY(0), .SERIAL_EN(1)) u_l0 (.clk(clk), .rst(rst), .bus(if_l0));
  full_adder_1bit #(.LATENCY(1), .SERIAL_EN(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1));
  full_adder_1bit #(.LATENCY(2), .SERIAL_EN(1)) u_l2 (.clk(clk), .rst(rst), .bus(if_l2));
  full_adder_1bit #(.LATENCY(3), .SERIAL_EN(1)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3));
  full_adder_1bit #(.LATENCY(0), .SERIAL_EN(0)) u_ns (.clk(clk), .rst(rst), .bus(if_ns));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: the word carry and the history of {sum, co, valid} results,
  // hist[k] being the result sampled k edges ago.
  bit       m_carry;
  bit [2:0] hist [1:3];
  bit       checking_on = 1'b0;

  function automatic bit [2:0] model_result(input bit sa, input bit sb, input bit sc, input bit v);
    int total;
    total = int'(sa) + int'(sb) + int'(sc);
    return {total % 2 == 1, total >= 2, v};
  endfunction

  function automatic bit model_ceff();
    if (serial_en) return serial_start ? 1'b0 : m_carry;
    return cin;
  endfunction

  always @(posedge clk) begin
    bit [2:0] r;
    if (rst) begin
      m_carry = 1'b0;
      for (int k = 1; k <= 3; k++) hist[k] = 3'b000;
      checking_on = 1'b1;
    end else begin
      r = model_result(a, b, model_ceff(), in_valid);
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = r;
      if (in_valid && serial_en) m_carry = r[1];
    end
  end

  always @(negedge clk) begin
    if (checking_on) begin
      chk("l0", {if_l0.sum, if_l0.co, if_l0.out_valid, if_l0.carry_q},
          {model_result(a, b, model_ceff(), in_valid), m_carry});
      chk("l1", {if_l1.sum, if_l1.co, if_l1.out_valid, if_l1.carry_q}, {hist[1], m_carry});
      chk("l2", {if_l2.sum, if_l2.co, if_l2.out_valid, if_l2.carry_q}, {hist[2], m_carry});
      chk("l3", {if_l3.sum, if_l3.co, if_l3.out_valid, if_l3.carry_q}, {hist[3], m_carry});
      chk("noserial", {if_ns.sum, if_ns.co, if_ns.out_valid, if_ns.carry_q},
          {model_result(a, b, cin, in_valid), 1'b0});
    end
  end

  task automatic drive(input bit r, input bit va, input bit vb, input bit vc,
                       input bit v, input bit se, input bit ss);
    @(posedge clk);
    #1;
    rst = r; a = va; b = vb; cin = vc;
    in_valid = v; serial_en = se; serial_start = ss;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  bit [2:0] pat    [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  bit       exp_s  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit       exp_co [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit [3:0] op_a = 4'b1011;
  bit [3:0] op_b = 4'b0111;
  bit [3:0] exp_bits = 4'b0010;
  int       result;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_l1", {if_l1.sum, if_l1.co, if_l1.out_valid, if_l1.carry_q}, 4'b0000);
    chk("reset_l3", {if_l3.sum, if_l3.co, if_l3.out_valid, if_l3.carry_q}, 4'b0000);

    // Truth table, combinational cell, external carry
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, pat[i][2], pat[i][1], pat[i][0], 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("truth_%b", pat[i]), {2'b00, if_l0.sum, if_l0.co}, {2'b00, exp_s[i], exp_co[i]});
    end
    idle(); idle(); idle();

    // One valid sample through the 2-stage pipe
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat2_e0", {3'b000, if_l2.out_valid}, 4'b0000);
    idle(); @(negedge clk);
    chk("lat2_e1", {3'b000, if_l2.out_valid}, 4'b0000);
    idle(); @(negedge clk);
    chk("lat2_e2", {1'b0, if_l2.sum, if_l2.co, if_l2.out_valid}, 4'b0111);
    idle(); @(negedge clk);
    chk("lat2_e3", {3'b000, if_l2.out_valid}, 4'b0000);

    // Serial 1011 + 0111, LSB first
    result = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, op_a[i], op_b[i], 1'b0, 1'b1, 1'b1, i == 0);
      @(negedge clk);
      chk($sformatf("serial_bit%0d", i), {3'b000, if_l0.sum}, {3'b000, exp_bits[i]});
      result = result | (int'(if_l0.sum) << i);
    end
    idle(); @(negedge clk);
    chk("serial_carry", {3'b000, if_l0.carry_q}, 4'b0001);
    result = result | (int'(if_l0.carry_q) << 4);
    chk("serial_result", result[3:0] ^ 4'(result >> 4) ^ 4'b0011, 4'b0011 ^ 4'b0010 ^ 4'b0001);

    // serial_start mid-stream with carry_q=1
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("start_mid_sumco", {2'b00, if_l0.sum, if_l0.co}, 4'b0000);
    idle(); @(negedge clk);
    chk("start_mid_carry", {3'b000, if_l0.carry_q}, 4'b0000);

    // serial_start without valid must not clear the carry
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(); @(negedge clk);
    chk("start_novalid_carry", {3'b000, if_l0.carry_q}, 4'b0001);

    // serial_en=0 uses cin and leaves the carry register alone
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("iso_sumco", {2'b00, if_l0.sum, if_l0.co}, 4'b0010);
    idle(); @(negedge clk);
    chk("iso_carry", {3'b000, if_l0.carry_q}, 4'b0001);

    // Reset beats a simultaneous valid serial sample
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstprio_l1", {if_l1.sum, if_l1.co, if_l1.out_valid, if_l1.carry_q}, 4'b0000);
    idle(); @(negedge clk);
    chk("rstprio_resume", {if_l1.sum, if_l1.co, if_l1.out_valid, if_l1.carry_q}, 4'b0110);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 4) == 0);
    end
    idle(); idle(); idle(); idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
